// File: rtl/multi_port_instr_mem_pkg.sv
// Shared address-decode helpers for the bank-interleaved instruction memory.
// Bank and word indices are derived from a byte address given the word offset and bank count.
package multi_port_instr_mem_pkg;

  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RAM_SIZE   = 65536;

  localparam int BANK_BITS      = $clog2(DEF_NUM_BANKS);
  localparam int WORDS_PER_BANK = DEF_RAM_SIZE / (DEF_NUM_BANKS * DEF_DATA_WIDTH / 8);

  function automatic int bank_idx(input logic [31:0] addr, input int w, input int nb);
    return int'((addr >> w) & 32'(nb - 1));
  endfunction

  function automatic int word_idx(input logic [31:0] addr, input int w, input int nb);
    return int'(addr >> (w + $clog2(nb)));
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter for one bank; the one-hot priority marks the port searched first.
// Priority moves to the port after the winner, so every requester waits at most N-1 grants.
module mem_rr_arb
  import multi_port_instr_mem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  logic [N-1:0] prio_q;
  logic [N-1:0] prio_nxt;
  logic         found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int s = 0; s < N; s++) begin
        if (!found && prio_q[s] && req_i[(s + k) % N]) begin
          gnt_o[(s + k) % N] = 1'b1;
          found              = 1'b1;
        end
      end
    end
    if (rst) gnt_o = '0;
  end

  always_comb begin
    prio_nxt = prio_q;
    if (|gnt_o) begin
      for (int i = 0; i < N; i++) prio_nxt[(i + 1) % N] = gnt_o[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= '0;
      prio_q[0] <= 1'b1;
    end else begin
      prio_q <= prio_nxt;
    end
  end

endmodule

// File: rtl/multi_port_instr_mem.sv
// Multi-ported, word-interleaved instruction memory: one round-robin arbiter and one
// single-port byte-enabled bank per interleave slot, fixed one-cycle response latency.
module multi_port_instr_mem
  import multi_port_instr_mem_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_SIZE   = 65536,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   req_i,
  output logic [NUM_PORTS-1:0]                   gnt_o,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0]                   we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]                   rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int W      = $clog2(NBYTES);
  localparam int BB     = $clog2(NUM_BANKS);
  localparam int BSW    = (BB > 0) ? BB : 1;
  localparam int NWORDS = RAM_SIZE / (NUM_BANKS * NBYTES);
  localparam int WB     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [BSW-1:0] pbank [NUM_PORTS];
  logic [WB-1:0]  pword [NUM_PORTS];

  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bgnt_all;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] brdata;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      pbank[p] = BSW'(bank_idx(32'(addr_i[p]), W, NUM_BANKS));
      pword[p] = WB'(word_idx(32'(addr_i[p]), W, NUM_BANKS));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_PORTS-1:0]  breq;
    logic [NUM_PORTS-1:0]  bgnt;
    logic [WB-1:0]         sword;
    logic                  swe;
    logic [NBYTES-1:0]     sbe;
    logic [DATA_WIDTH-1:0] swdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [NWORDS];

    always_comb begin
      breq = '0;
      for (int p = 0; p < NUM_PORTS; p++) breq[p] = req_i[p] && (pbank[p] == BSW'(b));
    end

    mem_rr_arb #(.N(NUM_PORTS)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (breq),
      .gnt_o (bgnt)
    );

    assign bgnt_all[b] = bgnt;

    always_comb begin
      sword  = '0;
      swe    = 1'b0;
      sbe    = '0;
      swdata = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bgnt[p]) begin
          sword  = pword[p];
          swe    = we_i[p];
          sbe    = be_i[p];
          swdata = wdata_i[p];
        end
      end
    end

    // Bank contents and read register are deliberately not reset.
    always_ff @(posedge clk) begin
      if (|bgnt) begin
        if (swe) begin
          for (int i = 0; i < NBYTES; i++)
            if (sbe[i]) mem[sword][i*8 +: 8] <= swdata[i*8 +: 8];
        end else begin
          rdata_q <= mem[sword];
        end
      end
    end

    assign brdata[b] = rdata_q;
  end

  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) gnt_o = gnt_o | bgnt_all[b];
  end

  logic [NUM_PORTS-1:0]                 rvalid_q;
  logic [NUM_PORTS-1:0]                 we_q;
  logic [BSW-1:0]                       tag_q [NUM_PORTS];
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= '0;
      we_q     <= '0;
      hold_q   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) tag_q[p] <= '0;
    end else begin
      rvalid_q <= gnt_o;
      hold_q   <= rdata_o;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt_o[p]) begin
          tag_q[p] <= pbank[p];
          we_q[p]  <= we_i[p];
        end
      end
    end
  end

  // The bank read register may be overwritten by later accesses, so the port keeps its own copy.
  always_comb begin
    rdata_o = hold_q;
    for (int p = 0; p < NUM_PORTS; p++)
      if (rvalid_q[p]) rdata_o[p] = we_q[p] ? '0 : brdata[tag_q[p]];
  end

  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_multi_port_instr_mem.sv
// Bench for multi_port_instr_mem: flat word-array reference model with per-bank round-robin
// pointers, checked every cycle, plus directed literal checks and randomized traffic.
module tb_multi_port_instr_mem;
  localparam int NP = 2;
  localparam int NB = 4;
  localparam int RAM_SIZE = 65536;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        req;
  logic [NP-1:0]        gnt;
  logic [NP-1:0][15:0]  addr;
  logic [NP-1:0]        we;
  logic [NP-1:0][3:0]   be;
  logic [NP-1:0][31:0]  wdata;
  logic [NP-1:0]        rvalid;
  logic [NP-1:0][31:0]  rdata;

  int total = 0;
  int bad = 0;

  multi_port_instr_mem #(.NUM_PORTS(NP), .NUM_BANKS(NB), .DATA_WIDTH(32), .RAM_SIZE(RAM_SIZE)) dut (
    .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference model: flat word memory, per-bank rr pointer, pending responses
  logic [31:0] mm [int];
  int          rr_m [NB];
  logic [NP-1:0] pend_v;
  logic [31:0] pend_d [NP];
  bit          pend_k [NP];
  logic [31:0] hold_d [NP];
  bit          hold_k [NP];

  initial begin
    pend_v = '0;
    for (int p = 0; p < NP; p++) begin pend_d[p] = 0; pend_k[p] = 0; hold_d[p] = 0; hold_k[p] = 0; end
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
  end

  always @(negedge clk) begin : cmp
    logic [NP-1:0] eg;
    logic [31:0]   t;
    int            w;
    if (rst) begin
      pend_v = '0;
      for (int p = 0; p < NP; p++) begin hold_d[p] = 0; hold_k[p] = 1; end
      for (int b = 0; b < NB; b++) rr_m[b] = 0;
    end
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rvalid[%0d]", p), 64'(rvalid[p]), 64'(pend_v[p]));
      if (pend_v[p]) begin
        hold_d[p] = pend_d[p];
        hold_k[p] = pend_k[p];
      end
      if (hold_k[p]) chk($sformatf("rdata[%0d]", p), 64'(rdata[p]), 64'(hold_d[p]));
    end
    eg = '0;
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        int sel;
        sel = -1;
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (rr_m[b] + k) % NP;
          if (sel < 0 && req[p] && ((int'(addr[p]) >> 2) % NB) == b) sel = p;
        end
        if (sel >= 0) begin
          eg[sel] = 1'b1;
          rr_m[b] = (sel + 1) % NP;
        end
      end
    end
    chk("gnt", 64'(gnt), 64'(eg));
    for (int p = 0; p < NP; p++) begin
      pend_v[p] = eg[p];
      if (eg[p]) begin
        w = int'(addr[p]) >> 2;
        if (we[p]) begin pend_d[p] = 0; pend_k[p] = 1; end
        else if (mm.exists(w)) begin pend_d[p] = mm[w]; pend_k[p] = 1; end
        else pend_k[p] = 0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (eg[p] && we[p]) begin
        w = int'(addr[p]) >> 2;
        if (mm.exists(w)) begin
          t = mm[w];
          for (int i = 0; i < 4; i++) if (be[p][i]) t[i*8 +: 8] = wdata[p][i*8 +: 8];
          mm[w] = t;
        end else if (be[p] == 4'hF) begin
          mm[w] = wdata[p];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input int p, input logic r, input logic [15:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d);
    req[p] = r; addr[p] = a; we[p] = w; be[p] = b; wdata[p] = d;
  endtask

  task automatic idle();
    for (int p = 0; p < NP; p++) set_p(p, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
  endtask

  function automatic logic [15:0] region_addr(input int wi);
    if (wi >= 64) return 16'hFFE0 + 16'((wi - 64) * 4);
    return 16'(wi * 4);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    logic [NP-1:0] lg;
    logic [15:0] wrap_a;
    rst = 1'b1;
    for (int p = 0; p < NP; p++) set_p(p, 1'b1, 16'h0, 1'b0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset gnt", 64'(gnt), 64'h0);
    chk("reset rvalid", 64'(rvalid), 64'h0);
    chk("reset rdata", 64'(rdata), 64'h0);

    cyc();
    rst = 1'b0;
    idle();
    set_p(0, 1'b1, 16'h0000, 1'b1, 4'hF, 32'hDEADBEEF);
    @(negedge clk); chk("first gnt", 64'(gnt), 64'h1);
    cyc(); idle();
    @(negedge clk); chk("first rvalid", 64'(rvalid), 64'h1);
    cyc();
    @(negedge clk); chk("first rvalid one cycle", 64'(rvalid), 64'h0);

    cyc();
    set_p(0, 1'b1, 16'h0010, 1'b1, 4'hF, 32'h11223344);
    set_p(1, 1'b1, 16'h0004, 1'b1, 4'hF, 32'h0BADF00D);
    cyc();
    set_p(0, 1'b1, 16'h0010, 1'b1, 4'h5, 32'hAABBCCDD);
    set_p(1, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    cyc();
    set_p(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
    cyc(); idle();
    @(negedge clk); chk("be read 0x10", 64'(rdata[0]), 64'h11BB33DD);

    cyc();
    set_p(0, 1'b1, 16'h0000, 1'b0, 4'h0, 32'h0);
    set_p(1, 1'b1, 16'h0004, 1'b0, 4'h0, 32'h0);
    @(negedge clk); chk("parallel gnt", 64'(gnt), 64'h3);
    cyc(); idle();
    @(negedge clk);
    chk("parallel rvalid", 64'(rvalid), 64'h3);
    chk("parallel rdata0", 64'(rdata[0]), 64'hDEADBEEF);
    chk("parallel rdata1", 64'(rdata[1]), 64'h0BADF00D);

    cyc();
    set_p(0, 1'b1, 16'h0008, 1'b0, 4'h0, 32'h0);
    set_p(1, 1'b1, 16'h0018, 1'b0, 4'h0, 32'h0);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fair gnt %0d", i), 64'(gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      c0 += int'(gnt[0]); c1 += int'(gnt[1]);
      cyc();
    end
    idle();
    chk("fair count0", 64'(c0), 64'd3);
    chk("fair count1", 64'(c1), 64'd3);

    wrap_a = 16'(RAM_SIZE);
    cyc();
    set_p(0, 1'b1, 16'hFFFC, 1'b1, 4'hF, 32'hCAFEF00D);
    cyc();
    set_p(0, 1'b1, 16'hFFFC, 1'b0, 4'h0, 32'h0);
    cyc();
    set_p(0, 1'b1, wrap_a, 1'b0, 4'h0, 32'h0);
    @(negedge clk); chk("top word", 64'(rdata[0]), 64'hCAFEF00D);
    cyc();
    set_p(0, 1'b1, 16'h0013, 1'b0, 4'h0, 32'h0);
    @(negedge clk); chk("wrap to word 0", 64'(rdata[0]), 64'hDEADBEEF);
    cyc(); idle();
    @(negedge clk); chk("misaligned 0x13", 64'(rdata[0]), 64'h11BB33DD);

    cyc();
    set_p(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
    @(negedge clk); chk("midflight gnt", 64'(gnt), 64'h1);
    #1 rst = 1'b1;
    cyc(); idle();
    cyc(); rst = 1'b0;
    @(negedge clk); chk("midflight no rvalid", 64'(rvalid), 64'h0);
    cyc();
    set_p(0, 1'b1, 16'h0010, 1'b0, 4'h0, 32'h0);
    cyc(); idle();
    @(negedge clk);
    chk("post reset rvalid", 64'(rvalid), 64'h1);
    chk("post reset data", 64'(rdata[0]), 64'h11BB33DD);

    for (int i = 0; i < 72; i += 2) begin
      cyc();
      set_p(0, 1'b1, region_addr(i), 1'b1, 4'hF, $urandom);
      set_p(1, 1'b1, region_addr(i + 1), 1'b1, 4'hF, $urandom);
    end
    cyc(); idle();

    lg = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      lg = gnt;
      cyc();
      rst = (c >= 1500 && c < 1502);
      for (int p = 0; p < NP; p++) begin
        if (req[p] && !lg[p]) begin
          if ($urandom_range(0, 9) == 0) req[p] = 1'b0;
        end else begin
          set_p(p, ($urandom_range(0, 3) != 0),
                region_addr($urandom_range(0, 71)) | 16'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
      end
    end
    cyc(); idle(); rst = 1'b0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
